ioctl_packer: RTL and testbench

IOCTL_PACKER -- requirements
Module: ioctl_packer

---
 rtl/ioctl_pkg.sv | 31 +++
 rtl/ioctl_packer_fifo.sv | 70 +++++++
 rtl/ioctl_packer.sv | 201 ++++++++++++++++++++
 tb/tb_ioctl_packer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ioctl_pkg
//  Purpose  : Shared types and constants for the ioctl byte-to-word packer.
//  Revision : 1.0  initial release
// ============================================================================
package ioctl_pkg;

   localparam int WADDR_W = 24;
   localparam int DATA_W  = 16;
   localparam int BE_W    = 2;
   localparam int ENTRY_W = WADDR_W + DATA_W + BE_W;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [WADDR_W-1:0] addr;
      logic [DATA_W-1:0]  data;
      logic [BE_W-1:0]    be;
   } entry_t;

   // Byte-enable bit for a byte lane; be[1] always selects data[15:8].
   function automatic logic [1:0] lane_be(input logic lane, input logic big_endian);
      return (lane ^ big_endian) ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ioctl_packer_fifo
//  Purpose  : Synchronous FIFO (power-of-two depth) with occupancy count.
//  Revision : 1.0  initial release
// ============================================================================
module ioctl_packer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int              PW       = $clog2(DEPTH);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/ioctl_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ioctl_packer
//  Purpose  : Packs ioctl download bytes into 16-bit memory write requests.
//             Optional checksum output enabled by IOCTL_PACKER_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ioctl_packer
   import ioctl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BIG_ENDIAN = 0
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         ioctl_download,
   input  logic         ioctl_wr,
   input  logic [24:0]  ioctl_addr,
   input  logic [7:0]   ioctl_dout,
   output logic         clkref_n,
   output logic         mem_req,
   output logic [23:0]  mem_addr,
   output logic [15:0]  mem_din,
   output logic [1:0]   mem_be,
   input  logic         mem_ack,
   output logic         done,
   output logic         overflow
`ifdef IOCTL_PACKER_CHECKSUM_EN
   ,
   output logic [15:0]  checksum
`endif
);

   localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  LOW_WATER = CW'(FIFO_DEPTH - 3);
   localparam logic           BE_MIRROR = (BIG_ENDIAN != 0);

   mem_state_t     state_q, state_d;
   entry_t         pend_q, pend_d;
   entry_t         req_q, req_d;
   entry_t         push_entry;
   entry_t         fifo_head;
   logic           pend_valid_q, pend_valid_d;
   logic           dl_q;
   logic           flush_q, flush_d;
   logic           done_q, done_d;
   logic           overflow_q, overflow_d;
   logic           clkref_n_q, clkref_n_d;

   logic           dl_rise, dl_fall, wr_ok, pend_live;
   logic           push, push_ok, pop;
   logic [23:0]    byte_addr;
   logic           byte_lane;
   logic [1:0]     byte_be;
   logic [15:0]    byte_data;
   logic [CW-1:0]  fifo_count;
   logic           fifo_empty, fifo_full;

   ioctl_packer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk_sys),
      .rst       (reset),
      .push      (push_ok),
      .push_data (push_entry),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_comb begin
      dl_rise   = ioctl_download & ~dl_q;
      dl_fall   = ~ioctl_download & dl_q;
      wr_ok     = ioctl_download & ioctl_wr;
      byte_addr = ioctl_addr[24:1];
      byte_lane = ioctl_addr[0];
      byte_be   = lane_be(byte_lane, BE_MIRROR);
      byte_data = byte_be[1] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      // A download start discards any half-word left over from before.
      pend_live = pend_valid_q & ~dl_rise;

      push         = 1'b0;
      push_entry   = pend_q;
      pend_d       = pend_q;
      pend_valid_d = pend_live;
      overflow_d   = overflow_q & ~dl_rise;
      flush_d      = flush_q;
      done_d       = 1'b0;

      if (wr_ok) begin
         if (pend_live && (pend_q.addr == byte_addr) && byte_lane) begin
            push         = 1'b1;
            push_entry   = '{addr: pend_q.addr,
                             data: pend_q.data | byte_data,
                             be:   pend_q.be | byte_be};
            pend_valid_d = 1'b0;
         end else begin
            push         = pend_live;
            pend_valid_d = 1'b1;
            pend_d       = '{addr: byte_addr, data: byte_data, be: byte_be};
         end
         if (push && fifo_full) begin
            overflow_d = 1'b1;
         end
      end else if (flush_q && pend_live && !fifo_full) begin
         push         = 1'b1;
         pend_valid_d = 1'b0;
      end

      if (dl_rise) begin
         flush_d = 1'b0;
      end else if (dl_fall) begin
         flush_d = 1'b1;
      end else if (flush_q && !pend_valid_q && fifo_empty && (state_q == ST_IDLE)) begin
         flush_d = 1'b0;
         done_d  = 1'b1;
      end

      push_ok    = push & ~fifo_full;
      clkref_n_d = ~((fifo_count <= LOW_WATER) && !flush_q);
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_REQ;
               req_d   = fifo_head;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         dl_q         <= 1'b0;
         flush_q      <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         clkref_n_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         dl_q         <= ioctl_download;
         flush_q      <= flush_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
         clkref_n_q   <= clkref_n_d;
      end
   end

   assign mem_req  = (state_q == ST_REQ);
   assign mem_addr = req_q.addr;
   assign mem_din  = req_q.data;
   assign mem_be   = req_q.be;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign clkref_n = clkref_n_q;

`ifdef IOCTL_PACKER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = dl_rise ? 16'h0000 : checksum_q;
      if (wr_ok) begin
         checksum_d = checksum_d + {8'h00, ioctl_dout};
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ioctl_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ioctl_packer
//  Purpose  : Directed self-checking bench for ioctl_packer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ioctl_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dl = 1'b0, wr = 1'b0;
   logic [24:0] addr = '0;
   logic [7:0]  dout = '0;
   logic        clkref_n, mem_req, mem_ack, done, overflow;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;

   logic        b_dl = 1'b0, b_wr = 1'b0;
   logic [24:0] b_addr_in = '0;
   logic [7:0]  b_dout = '0;
   logic        b_clkref_n, b_req, b_ack, b_done, b_overflow;
   logic [23:0] b_addr;
   logic [15:0] b_din;
   logic [1:0]  b_be;

   int errors = 0;
   int checks = 0;
   bit ack_en = 1'b0;
   int ack_delay = 0;
   int wait_cnt = 0;
   int gap_bad = 0;
   bit saw_high = 1'b0;
   logic [23:0] log_addr[$];
   logic [15:0] log_din[$];
   logic [1:0]  log_be[$];

   always #5 clk = ~clk;

   ioctl_packer #(.FIFO_DEPTH(4), .BIG_ENDIAN(0)) dut (
      .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
      .ioctl_addr(addr), .ioctl_dout(dout), .clkref_n(clkref_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
      .mem_ack(mem_ack), .done(done), .overflow(overflow)
   );

   ioctl_packer #(.FIFO_DEPTH(4), .BIG_ENDIAN(1)) dut_be (
      .clk_sys(clk), .reset(reset), .ioctl_download(b_dl), .ioctl_wr(b_wr),
      .ioctl_addr(b_addr_in), .ioctl_dout(b_dout), .clkref_n(b_clkref_n),
      .mem_req(b_req), .mem_addr(b_addr), .mem_din(b_din), .mem_be(b_be),
      .mem_ack(b_ack), .done(b_done), .overflow(b_overflow)
   );

   // Memory model: acks after ack_delay cycles and logs every completed word.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            if (mem_req) gap_bad++;
         end else if (mem_req && ack_en) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
               log_addr.push_back(mem_addr);
               log_din.push_back(mem_din);
               log_be.push_back(mem_be);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      b_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         b_ack = b_req && !b_ack;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit obey);
      int w = 0;
      if (obey) begin
         while (clkref_n && w < 200) begin
            saw_high = 1'b1;
            tick();
            w++;
         end
         if (w >= 200) begin
            checks++; errors++;
            $display("FAIL clkref_wait: clkref_n=%b still high after %0d cycles, required 0", clkref_n, w);
         end
      end
      addr = a; dout = d; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic wait_log(input int n);
      int w = 0;
      while (log_addr.size() < n && w < 500) begin
         tick();
         w++;
      end
      checks++;
      if (log_addr.size() < n) begin
         errors++;
         $display("FAIL log_count: got %0d words, required %0d", log_addr.size(), n);
      end
   endtask

   task automatic wait_done();
      int w = 0;
      while (!done && w < 300) begin
         tick();
         w++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse: done=%b, required 1 within bound", done);
      end else begin
         tick();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, required 0", done);
         end
      end
   endtask

   task automatic clear_log();
      log_addr.delete(); log_din.delete(); log_be.delete();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
      checks++; if (clkref_n !== 1'b1) begin errors++; $display("FAIL rst_clkref: got %b required 1", clkref_n); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b required 0", overflow); end
      checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", mem_addr); end
      checks++; if (mem_din !== 16'h0) begin errors++; $display("FAIL rst_din: got %h required 0", mem_din); end
      checks++; if (mem_be !== 2'b00) begin errors++; $display("FAIL rst_be: got %b required 00", mem_be); end
      reset = 1'b0;
      repeat (2) tick();
      checks++; if (clkref_n !== 1'b0) begin errors++; $display("FAIL idle_clkref: got %b required 0", clkref_n); end
   endtask

   task automatic test_pair();
      clear_log();
      ack_en = 1'b1; ack_delay = 0;
      dl = 1'b1; tick();
      send_byte(25'h0, 8'h11, 1'b1);
      send_byte(25'h1, 8'h22, 1'b1);
      wait_log(1);
      if (log_addr.size() >= 1) begin
         checks++; if (log_addr[0] !== 24'h0) begin errors++; $display("FAIL pair_addr: got %h required 000000", log_addr[0]); end
         checks++; if (log_din[0] !== 16'h2211) begin errors++; $display("FAIL pair_din: got %h required 2211", log_din[0]); end
         checks++; if (log_be[0] !== 2'b11) begin errors++; $display("FAIL pair_be: got %b required 11", log_be[0]); end
      end
      dl = 1'b0;
      wait_done();
      // Writes with download low must produce nothing.
      send_byte(25'h20, 8'h77, 1'b0);
      send_byte(25'h21, 8'h88, 1'b0);
      repeat (10) tick();
      checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL ignore_wr: got %0d words required 1", log_addr.size()); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ignore_req: got %b required 0", mem_req); end
   endtask

   task automatic test_big_endian();
      int w = 0;
      b_dl = 1'b1; tick();
      b_addr_in = 25'h0; b_dout = 8'h11; b_wr = 1'b1; tick();
      b_addr_in = 25'h1; b_dout = 8'h22; tick();
      b_wr = 1'b0;
      while (!b_req && w < 50) begin tick(); w++; end
      checks++; if (b_req !== 1'b1) begin errors++; $display("FAIL be_req: got %b required 1", b_req); end
      checks++; if (b_din !== 16'h1122) begin errors++; $display("FAIL be_din: got %h required 1122", b_din); end
      checks++; if (b_be !== 2'b11) begin errors++; $display("FAIL be_be: got %b required 11", b_be); end
      checks++; if (b_addr !== 24'h0) begin errors++; $display("FAIL be_addr: got %h required 000000", b_addr); end
      b_dl = 1'b0;
      w = 0;
      while (!b_done && w < 50) begin tick(); w++; end
      checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL be_done: got %b required 1", b_done); end
   endtask

   task automatic test_odd_tail();
      logic [23:0] ea [3] = '{24'h0, 24'h1, 24'h2};
      logic [15:0] ed [3] = '{16'h3130, 16'h3332, 16'h0034};
      logic [1:0]  eb [3] = '{2'b11, 2'b11, 2'b01};
      clear_log();
      ack_en = 1'b1; ack_delay = 2;
      dl = 1'b1; tick();
      for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(8'h30 + i), 1'b1);
      dl = 1'b0;
      wait_done();
      checks++; if (log_addr.size() !== 3) begin errors++; $display("FAIL tail_count: got %0d words required 3", log_addr.size()); end
      for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
         checks++; if (log_addr[i] !== ea[i]) begin errors++; $display("FAIL tail_addr%0d: got %h required %h", i, log_addr[i], ea[i]); end
         checks++; if (log_din[i] !== ed[i]) begin errors++; $display("FAIL tail_din%0d: got %h required %h", i, log_din[i], ed[i]); end
         checks++; if (log_be[i] !== eb[i]) begin errors++; $display("FAIL tail_be%0d: got %b required %b", i, log_be[i], eb[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] lo, hi;
      clear_log();
      ack_en = 1'b0; ack_delay = 0; saw_high = 1'b0;
      dl = 1'b1; tick();
      fork
         begin
            repeat (20) @(posedge clk);
            ack_en = 1'b1;
         end
         begin
            for (int i = 0; i < 12; i++) send_byte(25'(i), 8'(8'hA0 + i), 1'b1);
         end
      join
      dl = 1'b0;
      wait_done();
      checks++; if (saw_high !== 1'b1) begin errors++; $display("FAIL bp_clkref_high: got %b required 1", saw_high); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b required 0", overflow); end
      checks++; if (log_addr.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d words required 6", log_addr.size()); end
      for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
         lo = 8'(8'hA0 + 2 * i);
         hi = 8'(8'hA1 + 2 * i);
         checks++; if (log_addr[i] !== 24'(i)) begin errors++; $display("FAIL bp_addr%0d: got %h required %h", i, log_addr[i], 24'(i)); end
         checks++; if (log_din[i] !== {hi, lo}) begin errors++; $display("FAIL bp_din%0d: got %h required %h", i, log_din[i], {hi, lo}); end
      end
   endtask

   task automatic test_overflow();
      clear_log();
      ack_en = 1'b0; ack_delay = 0;
      dl = 1'b1; tick();
      for (int i = 0; i < 10; i++) send_byte(25'(8'h40 + i), 8'(i), 1'b0);
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
      ack_en = 1'b1;
      dl = 1'b0;
      wait_done();
      checks++; if (log_addr.size() !== 4) begin errors++; $display("FAIL ovf_count: got %0d words required 4", log_addr.size()); end
      if (log_addr.size() == 4) begin
         checks++; if (log_addr[3] !== 24'h23) begin errors++; $display("FAIL ovf_last_addr: got %h required 000023", log_addr[3]); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
      dl = 1'b1; tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
      dl = 1'b0;
      wait_done();
   endtask

   task automatic test_reset_in_req();
      int w = 0;
      clear_log();
      ack_en = 1'b0;
      dl = 1'b1; tick();
      send_byte(25'h10, 8'h55, 1'b1);
      send_byte(25'h11, 8'h66, 1'b1);
      while (!mem_req && w < 50) begin tick(); w++; end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h8) begin errors++; $display("FAIL rr_req: req=%b addr=%h required 1/000008", mem_req, mem_addr); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_mem_req: got %b required 0", mem_req); end
      checks++; if (clkref_n !== 1'b1) begin errors++; $display("FAIL rr_clkref: got %b required 1", clkref_n); end
      checks++; if (mem_din !== 16'h0) begin errors++; $display("FAIL rr_din: got %h required 0", mem_din); end
      dl = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      ack_en = 1'b1;
      w = 0;
      repeat (10) begin
         tick();
         if (mem_req || done) w++;
      end
      checks++; if (w !== 0) begin errors++; $display("FAIL rr_fifo_empty: %0d active cycles, required 0", w); end
      checks++; if (clkref_n !== 1'b0) begin errors++; $display("FAIL rr_clkref_after: got %b required 0", clkref_n); end
   endtask

   task automatic test_handshake_gap();
      checks++;
      if (gap_bad !== 0) begin errors++; $display("FAIL req_gap: %0d back-to-back requests, required 0", gap_bad); end
   endtask

   initial begin
      test_reset();
      test_pair();
      test_big_endian();
      test_odd_tail();
      test_backpressure();
      test_overflow();
      test_reset_in_req();
      test_handshake_gap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
